// File: rtl/freq_offset_track.sv
// Carrier-frequency-offset tracker: latches a per-sample phase offset on preamble detect and
// feeds the rotator with a wrapped running phase. Optional phase accumulator: FREQ_OFFSET_TRACK_EN.
module freq_offset_track #(
   parameter int PI        = 1608,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [31:0]          sample_in,
   input  logic                 sample_in_strobe,
   input  logic                 short_preamble_detected,
   input  logic [15:0]          phase_offset,
   input  logic                 packet_done,
   input  logic [CNT_WIDTH-1:0] max_samples,
   output logic [31:0]          rot_in,
   output logic [15:0]          rot_phase,
   output logic                 rot_in_stb,
   input  logic [31:0]          rot_out,
   input  logic                 rot_out_stb,
   output logic [31:0]          sample_out,
   output logic                 sample_out_strobe,
   output logic                 corr_active,
   output logic [15:0]          phase_acc
);

   localparam logic IDLE  = 1'b0;
   localparam logic TRACK = 1'b1;

   logic                 state;
   logic [CNT_WIDTH-1:0] count;
   logic [CNT_WIDTH-1:0] count_next;
   logic                 in_track;
   logic                 relock;
   logic                 advance;
   logic                 timeout;

   // corr_active is the state register itself, so it doubles as the FSM debug view.
   assign corr_active = state;
   assign in_track    = (state == TRACK);

   // Detect in IDLE locks; in TRACK only a detect coinciding with packet_done relocks.
   assign relock  = enable && short_preamble_detected && (!in_track || packet_done);
   assign advance = enable && in_track && sample_in_strobe && !packet_done;
   assign count_next = count + CNT_WIDTH'(1);
   assign timeout = advance && (max_samples != '0) && (count_next == max_samples);

   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         count             <= '0;
         rot_in            <= '0;
         rot_in_stb        <= 1'b0;
         sample_out        <= '0;
         sample_out_strobe <= 1'b0;
      end else begin
         rot_in_stb        <= 1'b0;
         sample_out_strobe <= 1'b0;
         if (enable) begin
            if (sample_in_strobe) begin
               rot_in     <= sample_in;
               rot_in_stb <= 1'b1;
            end
            if (rot_out_stb) begin
               sample_out        <= rot_out;
               sample_out_strobe <= 1'b1;
            end
            if (relock) begin
               state <= TRACK;
               count <= '0;
            end else if (in_track && packet_done) begin
               state <= IDLE;
            end else if (advance) begin
               count <= count_next;
               if (timeout) state <= IDLE;
            end
         end
      end
   end

`ifdef FREQ_OFFSET_TRACK_EN
   localparam logic signed [16:0] PI17   = 17'(PI);
   localparam logic signed [16:0] TWO_PI = 17'(2 * PI);

   logic signed [15:0] acc;
   logic signed [15:0] offset_reg;

   // One correction is enough because |offset| never exceeds PI.
   function automatic logic signed [15:0] wrap_add(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
      logic signed [16:0] s;
      s = {a[15], a} + {b[15], b};
      if (s > PI17)
         s = s - TWO_PI;
      else if (s < -PI17)
         s = s + TWO_PI;
      return s[15:0];
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         acc        <= '0;
         offset_reg <= '0;
         rot_phase  <= '0;
      end else if (enable) begin
         if (sample_in_strobe)
            rot_phase <= in_track ? acc : 16'sd0;
         if (relock) begin
            offset_reg <= phase_offset;
            acc        <= '0;
         end else if (advance) begin
            acc <= wrap_add(acc, offset_reg);
         end
      end
   end

   assign phase_acc = acc;
`else
   logic unused_cfg;

   assign unused_cfg = ^{phase_offset, PI[15:0]};
   assign rot_phase  = '0;
   assign phase_acc  = '0;
`endif

endmodule

// File: tb/tb_freq_offset_track.sv
// Directed bench for freq_offset_track: a vector table for the basic packet flow plus
// hand-written sequences for wrap, timeout, relock, enable gating and mid-packet reset.
module tb_freq_offset_track;

`ifdef FREQ_OFFSET_TRACK_EN
   localparam bit PHASE_EN = 1'b1;
`else
   localparam bit PHASE_EN = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic        enable;
   logic [31:0] sample_in;
   logic        sample_in_strobe;
   logic        short_preamble_detected;
   logic [15:0] phase_offset;
   logic        packet_done;
   logic [31:0] max_samples;
   logic [31:0] rot_in;
   logic [15:0] rot_phase;
   logic        rot_in_stb;
   logic [31:0] rot_out;
   logic        rot_out_stb;
   logic [31:0] sample_out;
   logic        sample_out_strobe;
   logic        corr_active;
   logic [15:0] phase_acc;

   int n_pass  = 0;
   int n_total = 0;

   freq_offset_track dut (
      .clock                   (clock),
      .reset                   (reset),
      .enable                  (enable),
      .sample_in               (sample_in),
      .sample_in_strobe        (sample_in_strobe),
      .short_preamble_detected (short_preamble_detected),
      .phase_offset            (phase_offset),
      .packet_done             (packet_done),
      .max_samples             (max_samples),
      .rot_in                  (rot_in),
      .rot_phase               (rot_phase),
      .rot_in_stb              (rot_in_stb),
      .rot_out                 (rot_out),
      .rot_out_stb             (rot_out_stb),
      .sample_out              (sample_out),
      .sample_out_strobe       (sample_out_strobe),
      .corr_active             (corr_active),
      .phase_acc               (phase_acc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        stb;
      logic        spd;
      logic        pd;
      logic [15:0] off;
      logic [31:0] smp;
      logic        ros;
      logic [31:0] ro;
      logic        e_stb;
      int          e_phase;
      logic        e_active;
      logic        chk_acc;
      int          e_acc;
      logic        e_sos;
   } vec_t;

   vec_t vecs[9];

   // Expected phase: the running phase when the accumulator is built, otherwise always 0.
   function automatic logic [15:0] ph(input int v);
      logic [31:0] t;
      t = v;
      return PHASE_EN ? t[15:0] : 16'd0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic step(input logic stb, input logic spd, input logic pd,
                       input logic [15:0] off, input logic [31:0] smp,
                       input logic ros, input logic [31:0] ro);
      sample_in_strobe        = stb;
      short_preamble_detected = spd;
      packet_done             = pd;
      phase_offset            = off;
      sample_in               = smp;
      rot_out_stb             = ros;
      rot_out                 = ro;
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 16'd0, 32'd0, 0, 32'd0);
   endtask

   task automatic strobe(input logic [31:0] smp);
      step(1, 0, 0, 16'd0, smp, 0, 32'd0);
   endtask

   task automatic detect(input int off);
      logic [31:0] t;
      t = off;
      step(0, 1, 0, t[15:0], 32'd0, 0, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      reset = 1'b0;
   endtask

   function automatic vec_t mk(input logic stb, input logic spd, input logic pd, input int off,
                               input logic [31:0] smp, input logic ros, input logic [31:0] ro,
                               input logic e_stb, input int e_phase, input logic e_active,
                               input logic chk_acc, input int e_acc, input logic e_sos);
      vec_t v;
      logic [31:0] t;
      t = off;
      v.stb = stb; v.spd = spd; v.pd = pd; v.off = t[15:0]; v.smp = smp;
      v.ros = ros; v.ro = ro; v.e_stb = e_stb; v.e_phase = e_phase;
      v.e_active = e_active; v.chk_acc = chk_acc; v.e_acc = e_acc; v.e_sos = e_sos;
      return v;
   endfunction

   initial begin
      // detect+strobe same cycle: sample uses IDLE rules (phase 0)
      vecs[0] = mk(1, 1, 0, 100, 32'h1111_0001, 0, 32'd0,        1, 0,   1, 1, 0,   0);
      vecs[1] = mk(1, 0, 0, 0,   32'h2222_0002, 0, 32'd0,        1, 0,   1, 1, 100, 0);
      vecs[2] = mk(1, 0, 0, 0,   32'h3333_0003, 0, 32'd0,        1, 100, 1, 1, 200, 0);
      vecs[3] = mk(1, 0, 0, 0,   32'h4444_0004, 0, 32'd0,        1, 200, 1, 1, 300, 0);
      vecs[4] = mk(1, 0, 0, 0,   32'h5555_0005, 0, 32'd0,        1, 300, 1, 1, 400, 0);
      vecs[5] = mk(1, 0, 0, 0,   32'h6666_0006, 1, 32'hABCD_1234, 1, 400, 1, 1, 500, 1);
      // detect alone in TRACK is ignored
      vecs[6] = mk(0, 1, 0, 7,   32'd0,         0, 32'd0,        0, 0,   1, 1, 500, 0);
      // strobe with packet_done uses current phase, then exits
      vecs[7] = mk(1, 0, 1, 0,   32'h7777_0007, 0, 32'd0,        1, 500, 0, 0, 0,   0);
      vecs[8] = mk(1, 0, 0, 0,   32'h8888_0008, 1, 32'h0F0F_F0F0, 1, 0,   0, 0, 0,   1);

      reset = 1'b1; enable = 1'b1; max_samples = 32'd0;
      sample_in = '0; sample_in_strobe = 0; short_preamble_detected = 0;
      phase_offset = '0; packet_done = 0; rot_out = '0; rot_out_stb = 0;
      repeat (3) @(posedge clock);
      #1;
      check("reset rot_in_stb", {31'd0, rot_in_stb}, 32'd0);
      check("reset corr_active", {31'd0, corr_active}, 32'd0);
      check("reset phase_acc", {16'd0, phase_acc}, 32'd0);
      check("reset rot_phase", {16'd0, rot_phase}, 32'd0);
      check("reset rot_in", rot_in, 32'd0);
      check("reset sample_out", sample_out, 32'd0);
      check("reset sample_out_strobe", {31'd0, sample_out_strobe}, 32'd0);
      reset = 1'b0;
      idle();

      // IDLE forwarding with phase 0
      strobe(32'hCAFE_0001);
      check("idle rot_in_stb", {31'd0, rot_in_stb}, 32'd1);
      check("idle rot_in", rot_in, 32'hCAFE_0001);
      check("idle rot_phase", {16'd0, rot_phase}, 32'd0);
      idle();
      check("idle stb falls", {31'd0, rot_in_stb}, 32'd0);

      for (int i = 0; i < 9; i++) begin
         step(vecs[i].stb, vecs[i].spd, vecs[i].pd, vecs[i].off, vecs[i].smp,
              vecs[i].ros, vecs[i].ro);
         check($sformatf("vec%0d rot_in_stb", i), {31'd0, rot_in_stb}, {31'd0, vecs[i].e_stb});
         if (vecs[i].e_stb) begin
            check($sformatf("vec%0d rot_in", i), rot_in, vecs[i].smp);
            check($sformatf("vec%0d rot_phase", i), {16'd0, rot_phase},
                  {16'd0, ph(vecs[i].e_phase)});
         end
         check($sformatf("vec%0d corr_active", i), {31'd0, corr_active},
               {31'd0, vecs[i].e_active});
         if (vecs[i].chk_acc)
            check($sformatf("vec%0d phase_acc", i), {16'd0, phase_acc},
                  {16'd0, ph(vecs[i].e_acc)});
         check($sformatf("vec%0d sample_out_strobe", i), {31'd0, sample_out_strobe},
               {31'd0, vecs[i].e_sos});
         if (vecs[i].e_sos)
            check($sformatf("vec%0d sample_out", i), sample_out, vecs[i].ro);
      end

      // positive wrap: 16 steps of 100 reach 1600, then 1700 wraps to -1516
      do_reset();
      detect(100);
      for (int k = 0; k <= 16; k++) begin
         strobe(32'(k));
         check($sformatf("wrap+ phase k=%0d", k), {16'd0, rot_phase}, {16'd0, ph(k * 100)});
      end
      check("wrap+ acc", {16'd0, phase_acc}, {16'd0, ph(-1516)});
      strobe(32'd99);
      check("wrap+ next phase", {16'd0, rot_phase}, {16'd0, ph(-1516)});

      // negative wrap: -1700 wraps to 1516
      do_reset();
      detect(-100);
      for (int k = 0; k <= 16; k++) begin
         strobe(32'(k));
         if (k == 16)
            check("wrap- phase -1600", {16'd0, rot_phase}, {16'd0, ph(-1600)});
      end
      check("wrap- acc", {16'd0, phase_acc}, {16'd0, ph(1516)});
      strobe(32'd98);
      check("wrap- next phase", {16'd0, rot_phase}, {16'd0, ph(1516)});

      // timeout after 3 samples
      do_reset();
      max_samples = 32'd3;
      detect(10);
      for (int k = 0; k < 3; k++) begin
         strobe(32'h100 + 32'(k));
         check($sformatf("timeout phase %0d", k), {16'd0, rot_phase}, {16'd0, ph(k * 10)});
         check($sformatf("timeout active %0d", k), {31'd0, corr_active},
               (k < 2) ? 32'd1 : 32'd0);
      end
      strobe(32'h200);
      check("timeout 4th stb", {31'd0, rot_in_stb}, 32'd1);
      check("timeout 4th phase", {16'd0, rot_phase}, 32'd0);
      check("timeout 4th active", {31'd0, corr_active}, 32'd0);
      max_samples = 32'd0;

      // relock on detect + packet_done
      do_reset();
      detect(70);
      strobe(32'd1);
      strobe(32'd2);
      check("relock pre phase", {16'd0, rot_phase}, {16'd0, ph(70)});
      step(0, 1, 1, 16'hFFCE, 32'd0, 0, 32'd0);
      check("relock active", {31'd0, corr_active}, 32'd1);
      check("relock acc", {16'd0, phase_acc}, 32'd0);
      strobe(32'd3);
      check("relock phase0", {16'd0, rot_phase}, 32'd0);
      strobe(32'd4);
      check("relock phase1", {16'd0, rot_phase}, {16'd0, ph(-50)});
      detect(999);
      check("detect ignored active", {31'd0, corr_active}, 32'd1);
      strobe(32'd5);
      check("detect ignored phase", {16'd0, rot_phase}, {16'd0, ph(-100)});

      // enable low freezes tracking
      do_reset();
      detect(100);
      strobe(32'd1);
      strobe(32'd2);
      idle();
      enable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 0, 16'd0, 32'h900 + 32'(k), 1, 32'h55);
         check($sformatf("en_low rot_in_stb %0d", k), {31'd0, rot_in_stb}, 32'd0);
         check($sformatf("en_low sos %0d", k), {31'd0, sample_out_strobe}, 32'd0);
         check($sformatf("en_low acc %0d", k), {16'd0, phase_acc}, {16'd0, ph(200)});
      end
      enable = 1'b1;
      strobe(32'hA00);
      check("en_high phase", {16'd0, rot_phase}, {16'd0, ph(200)});
      check("en_high acc", {16'd0, phase_acc}, {16'd0, ph(300)});
      check("en_high active", {31'd0, corr_active}, 32'd1);

      // reset mid-TRACK; in-flight rotator result still forwarded
      detect(5);
      strobe(32'd1);
      strobe(32'd2);
      reset = 1'b1;
      strobe(32'd3);
      reset = 1'b0;
      check("midreset active", {31'd0, corr_active}, 32'd0);
      check("midreset acc", {16'd0, phase_acc}, 32'd0);
      step(1, 0, 0, 16'd0, 32'hBEEF, 1, 32'h1234_5678);
      check("midreset phase", {16'd0, rot_phase}, 32'd0);
      check("midreset stb", {31'd0, rot_in_stb}, 32'd1);
      check("midreset sample_out", sample_out, 32'h1234_5678);
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/freq_offset_track.md
# freq_offset_track

Carrier-frequency-offset tracker between short-preamble detection and long-preamble sync. On a short-preamble detect pulse it latches the per-sample phase offset estimate, runs a wrapped phase accumulator across the packet, and drives an external rotator (CORDIC) with each sample plus its correction phase. It also registers the rotator result as the corrected sample stream for long sync. It returns to idle on packet end, on a sample-count timeout, or on reset.

## Interface
- PI, 1608, fixed-point pi (3.1416 * 512); phase range is [-PI, PI].
- CNT_WIDTH, 32, width of the in-packet sample counter and `max_samples`.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- enable  in  1  clock enable; when low, state is frozen and output strobes are 0.
- sample_in  in  32  I in [31:16], Q in [15:0], signed.
- sample_in_strobe  in  1  `sample_in` valid.
- short_preamble_detected  in  1  single-cycle detect pulse.
- phase_offset  in  16  signed per-sample phase correction; already negated and divided by 16.
- packet_done  in  1  pulse from downstream: packet finished.
- max_samples  in  CNT_WIDTH  timeout in samples; 0 disables the timeout.
- rot_in  out  32  sample to rotator.
- rot_phase  out  16  signed correction phase paired with `rot_in`.
- rot_in_stb  out  1  rotator input valid.
- rot_out  in  32  rotated sample from rotator.
- rot_out_stb  in  1  `rot_out` valid.
- sample_out  out  32  corrected sample.
- sample_out_strobe  out  1  `sample_out` valid.
- corr_active  out  1  high while in TRACK.
- phase_acc  out  16  current accumulator value (signed).

## Operation
- Reset values:
  - all outputs 0; state IDLE.
  - internal registers `offset_reg`, accumulator and sample counter 0.
- IDLE:
  - each `sample_in_strobe` forwards the sample to `rot_in` with `rot_phase`=0.
  - on `short_preamble_detected`: `offset_reg`<=`phase_offset`, accumulator<=0, count<=0, state<=TRACK.
- TRACK:
  - each `sample_in_strobe`: `rot_in`<=`sample_in`, `rot_phase`<=accumulator (pre-update value), accumulator<=wrap(accumulator+`offset_reg`), count<=count+1.
- wrap(x), computed with 17-bit signed intermediate:
  - x>PI: x-2*PI.
  - x<-PI: x+2*PI.
  - otherwise x.
  - A single correction suffices because |offset| <= PI.
- Exit TRACK -> IDLE on either:
  - `packet_done`; or
  - `max_samples`!=0 and count reaches `max_samples` (the transition happens on the strobe that makes count==`max_samples`; that sample still uses the accumulated phase).
- Simultaneous events:
  - `short_preamble_detected` in TRACK without `packet_done`: ignored; no relock.
  - `short_preamble_detected` together with `packet_done`: relock. New offset latched, accumulator and count cleared, stay in TRACK.
  - `sample_in_strobe` in the same cycle as entering TRACK: processed with IDLE rules (phase 0).
  - `sample_in_strobe` in the same cycle as `packet_done`: uses the current accumulator, then exits.
- Output path: on `rot_out_stb`, `sample_out`<=`rot_out`. The rotator latency is external and the block passes it through transparently.
- `enable` low: no state update. `rot_in_stb`, `sample_out_strobe` and all input pulses are ignored (pulses are lost).

## Timing
- `rot_in_stb` / `rot_in` / `rot_phase`: 1 cycle after `sample_in_strobe`.
- `sample_out_strobe`: 1 cycle after `rot_out_stb`.
- `corr_active` and `phase_acc` are registered. `corr_active` rises 1 cycle after the detect pulse and falls 1 cycle after the exit event.
- Throughput: one sample per cycle; no backpressure.
- Reset mid-packet: the next cycle is IDLE with accumulator 0. Rotator results already in flight are still forwarded to `sample_out`.

## Configuration
- `FREQ_OFFSET_TRACK_EN`
  - Defined: behaviour as above.
  - Undefined:
    - `rot_phase` is always 0; the accumulator is not built and `phase_acc` reads 0.
    - The state machine, `corr_active`, the counter/timeout and all strobe timing are unchanged (bit-identical timing, uncorrected samples).

## Test plan
- Reset mid-TRACK -> next cycle: `corr_active`=0, `phase_acc`=0; the next sample has `rot_phase`=0.
- Detect with `phase_offset`=100, then 5 strobes -> `rot_phase` sequence 0,100,200,300,400; `rot_in_stb` 1 cycle after each strobe.
- `phase_offset`=100, accumulator at 1600, one strobe -> `rot_phase`=1600; next accumulator = 1700-3216 = -1516. Same with -100 at -1600 -> -1700+3216 = 1516.
- `max_samples`=3 -> exactly 3 strobes in TRACK, `corr_active` falls 1 cycle after the 3rd; the 4th strobe has `rot_phase`=0.
- `short_preamble_detected` + `packet_done` in the same cycle, new offset -50 -> stays TRACK; next samples get `rot_phase` 0,-50. Detect alone in TRACK -> no change.
- `enable` low for 4 cycles mid-TRACK with strobes -> no `rot_in_stb`, `phase_acc` held; progression resumes from the held value when `enable` returns high.
